exit_status_blinker: RTL and testbench



---
 rtl/exit_status_blinker.sv | 159 +++++++++++++++
 tb/tb_exit_status_blinker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_status_blinker.sv
// rtl/exit_status_blinker.sv - latches the first exit report and shows pass/fail plus a blink-coded exit value
//
// Ports:
//   clk_i            core clock
//   rst_ni           synchronous active-low reset
//   exit_valid_i     exit report valid (level); a 0->1 rise is a new report
//   exit_value_i     exit code, sampled on the rise
//   clear_i          synchronous return to IDLE (captured value kept)
//   busy_o           a report is latched
//   captured_value_o latched exit code
//   pass_led_o       steady on when the latched code is zero
//   fail_led_o       steady on when the latched code is non-zero
//   code_led_o       low NBITS bits of the code, MSB first, four slots per bit
module exit_status_blinker #(
    parameter int TICK_CYCLES = 12500000,
    parameter int NBITS       = 8,
    parameter int GAP_SLOTS   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    input  logic        clear_i,
    output logic        busy_o,
    output logic [31:0] captured_value_o,
    output logic        pass_led_o,
    output logic        fail_led_o,
    output logic        code_led_o
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_SLOTS - 1);
    localparam logic [4:0]    BIT_TOP  = 5'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_BLINK = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_valid_q;
    logic [31:0]   r_captured;
    logic [TW-1:0] r_tick;
    logic [4:0]    r_bit;
    logic [1:0]    r_sub;
    logic [GW-1:0] r_gap;

    state_t        w_state_n;
    logic [31:0]   w_captured_n;
    logic [TW-1:0] w_tick_n;
    logic [4:0]    w_bit_n;
    logic [1:0]    w_sub_n;
    logic [GW-1:0] w_gap_n;

    logic w_rise;
    logic w_slot_end;
    logic w_cur_bit;

    assign w_rise     = exit_valid_i && !r_valid_q;
    assign w_slot_end = (r_tick == TICK_MAX);
    assign w_cur_bit  = r_captured[r_bit];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_valid_q  <= 1'b0;
            r_captured <= '0;
            r_tick     <= '0;
            r_bit      <= '0;
            r_sub      <= '0;
            r_gap      <= '0;
        end else begin
            // Tracks the input even across clear so a held-high valid is not re-captured.
            r_valid_q  <= exit_valid_i;
            r_state    <= w_state_n;
            r_captured <= w_captured_n;
            r_tick     <= w_tick_n;
            r_bit      <= w_bit_n;
            r_sub      <= w_sub_n;
            r_gap      <= w_gap_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_captured_n = r_captured;
        w_tick_n     = r_tick;
        w_bit_n      = r_bit;
        w_sub_n      = r_sub;
        w_gap_n      = r_gap;

        if (clear_i) begin
            // Clear beats a simultaneous rise; the captured value is kept for inspection.
            w_state_n = S_IDLE;
            w_tick_n  = '0;
            w_bit_n   = '0;
            w_sub_n   = '0;
            w_gap_n   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_captured_n = exit_value_i;
                        w_tick_n     = '0;
                        w_bit_n      = BIT_TOP;
                        w_sub_n      = '0;
                        w_gap_n      = '0;
                        w_state_n    = (exit_value_i == 32'd0) ? S_PASS : S_BLINK;
                    end
                end
                S_PASS: begin
                end
                S_BLINK: begin
                    w_tick_n = w_slot_end ? '0 : r_tick + 1'b1;
                    if (w_slot_end) begin
                        if (r_sub == 2'd3) begin
                            w_sub_n = '0;
                            if (r_bit == 5'd0) begin
                                w_state_n = S_GAP;
                                w_gap_n   = '0;
                            end else begin
                                w_bit_n = r_bit - 1'b1;
                            end
                        end else begin
                            w_sub_n = r_sub + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    w_tick_n = w_slot_end ? '0 : r_tick + 1'b1;
                    if (w_slot_end) begin
                        if (r_gap == GAP_MAX) begin
                            w_state_n = S_BLINK;
                            w_bit_n   = BIT_TOP;
                            w_sub_n   = '0;
                        end else begin
                            w_gap_n = r_gap + 1'b1;
                        end
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    assign busy_o           = (r_state != S_IDLE);
    assign captured_value_o = r_captured;
    assign pass_led_o       = (r_state == S_PASS);
    assign fail_led_o       = (r_state == S_BLINK) || (r_state == S_GAP);
    // Sub-slot 0 is always lit; a '1' bit stays lit through sub-slot 2.
    assign code_led_o       = (r_state == S_BLINK) &&
                              ((r_sub == 2'd0) || (w_cur_bit && (r_sub != 2'd3)));

endmodule

// File: tb/tb_exit_status_blinker.sv
// tb/tb_exit_status_blinker.sv - self-checking bench for exit_status_blinker
module tb_exit_status_blinker;

    localparam int TICK  = 4;
    localparam int NB    = 4;
    localparam int GAP   = 2;
    localparam int FRAME = (4 * NB + GAP) * TICK;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exit_valid;
    logic [31:0] exit_value;
    logic        clear;
    logic        busy;
    logic [31:0] captured;
    logic        pass_led;
    logic        fail_led;
    logic        code_led;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_cap = 32'd0;

    always #5 clk = ~clk;

    exit_status_blinker #(
        .TICK_CYCLES (TICK),
        .NBITS       (NB),
        .GAP_SLOTS   (GAP)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .exit_valid_i     (exit_valid),
        .exit_value_i     (exit_value),
        .clear_i          (clear),
        .busy_o           (busy),
        .captured_value_o (captured),
        .pass_led_o       (pass_led),
        .fail_led_o       (fail_led),
        .code_led_o       (code_led)
    );

    // Expected {busy, pass, fail, code} k cycles after the first busy cycle of a capture of v.
    function automatic logic [3:0] exp_leds(input logic [31:0] v, input int k);
        int   slot;
        int   b;
        int   s;
        logic code;
        slot = (k % FRAME) / TICK;
        code = 1'b0;
        if (v != 32'd0 && slot < 4 * NB) begin
            b    = NB - 1 - slot / 4;
            s    = slot % 4;
            code = (s == 0) || (v[b] && s < 3);
        end
        return {1'b1, v == 32'd0, v != 32'd0, code};
    endfunction

    function automatic logic [3:0] obs_leds();
        return {busy, pass_led, fail_led, code_led};
    endfunction

    task automatic drop_valid();
        @(negedge clk);
        exit_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic raise(input logic [31:0] v);
        exit_valid = 1'b1;
        exit_value = v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        clear      = 1'b0;
        exit_valid = 1'($urandom);
        exit_value = $urandom;
        repeat (3) @(negedge clk);
        n_vec++;
        if (obs_leds() !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_leds got %b want 0000", obs_leds());
        end
        n_vec++;
        if (captured !== 32'd0) begin
            n_err++;
            $display("FAIL reset_captured got %h want 0", captured);
        end
        rst_n      = 1'b1;
        exit_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (obs_leds() !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset got %b want 0000", obs_leds());
        end
    endtask

    task automatic test_pass();
        drop_valid();
        raise(32'd0);
        last_cap = 32'd0;
        for (int k = 0; k < 200; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(32'd0, k) || captured !== 32'd0) begin
                n_err++;
                $display("FAIL pass k=%0d got %b/%h want %b/0", k, obs_leds(), captured, exp_leds(32'd0, k));
            end
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_vec++;
        if (obs_leds() !== 4'b0000) begin
            n_err++;
            $display("FAIL pass_clear got %b want 0000", obs_leds());
        end
    endtask

    task automatic test_blink();
        logic [31:0] v;
        int          n;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      v = 32'h5;
            else if (i == 1) v = 32'h100;
            else begin
                v = $urandom;
                if ($urandom_range(0, 3) == 0) v = v & ~32'hF;
            end
            n = (i < 2) ? 2 * FRAME : int'($urandom_range(1, 160));
            drop_valid();
            raise(v);
            last_cap = v;
            for (int k = 0; k < n; k++) begin
                n_vec++;
                if (obs_leds() !== exp_leds(v, k) || captured !== v) begin
                    n_err++;
                    $display("FAIL blink v=%h k=%0d got %b/%h want %b", v, k, obs_leds(), captured, exp_leds(v, k));
                end
                @(negedge clk);
            end
            clear      = 1'b1;
            exit_valid = 1'b0;
            @(negedge clk);
            clear = 1'b0;
            n_vec++;
            if (obs_leds() !== 4'b0000 || captured !== v) begin
                n_err++;
                $display("FAIL blink_clear v=%h got %b/%h want 0000/%h", v, obs_leds(), captured, v);
            end
        end
    endtask

    task automatic test_clear_held();
        drop_valid();
        raise(32'h3);
        last_cap = 32'h3;
        for (int k = 0; k < 25; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(32'h3, k)) begin
                n_err++;
                $display("FAIL held_blink k=%0d got %b want %b", k, obs_leds(), exp_leds(32'h3, k));
            end
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 30; k++) begin
            n_vec++;
            if (obs_leds() !== 4'b0000 || captured !== 32'h3) begin
                n_err++;
                $display("FAIL held_no_recapture k=%0d got %b/%h want 0000/3", k, obs_leds(), captured);
            end
            @(negedge clk);
        end
        exit_valid = 1'b0;
        @(negedge clk);
        raise(32'd0);
        last_cap = 32'd0;
        for (int k = 0; k < 20; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(32'd0, k) || captured !== 32'd0) begin
                n_err++;
                $display("FAIL held_repass k=%0d got %b/%h want %b/0", k, obs_leds(), captured, exp_leds(32'd0, k));
            end
            @(negedge clk);
        end
        clear      = 1'b1;
        exit_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_clear_rise();
        drop_valid();
        exit_valid = 1'b1;
        exit_value = $urandom | 32'h1;
        clear      = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (obs_leds() !== 4'b0000 || captured !== last_cap) begin
                n_err++;
                $display("FAIL clear_rise k=%0d got %b/%h want 0000/%h", k, obs_leds(), captured, last_cap);
            end
            @(negedge clk);
        end
        exit_valid = 1'b0;
        @(negedge clk);
        raise(32'h9);
        last_cap = 32'h9;
        for (int k = 0; k < FRAME + 8; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(32'h9, k) || captured !== 32'h9) begin
                n_err++;
                $display("FAIL second_rise k=%0d got %b/%h want %b/9", k, obs_leds(), captured, exp_leds(32'h9, k));
            end
            @(negedge clk);
        end
        clear      = 1'b1;
        exit_valid = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset_gap();
        logic [31:0] v;
        drop_valid();
        raise(32'hF);
        last_cap = 32'hF;
        // Slots 16 and 17 of the frame are the gap; stop inside it.
        for (int k = 0; k < 4 * NB * TICK + 2; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(32'hF, k)) begin
                n_err++;
                $display("FAIL pre_gap k=%0d got %b want %b", k, obs_leds(), exp_leds(32'hF, k));
            end
            @(negedge clk);
        end
        rst_n      = 1'b0;
        exit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (obs_leds() !== 4'b0000 || captured !== 32'd0) begin
            n_err++;
            $display("FAIL gap_reset got %b/%h want 0000/0", obs_leds(), captured);
        end
        v = $urandom | 32'h2;
        raise(v);
        last_cap = v;
        for (int k = 0; k < FRAME + 4; k++) begin
            n_vec++;
            if (obs_leds() !== exp_leds(v, k) || captured !== v) begin
                n_err++;
                $display("FAIL post_reset v=%h k=%0d got %b/%h want %b", v, k, obs_leds(), captured, exp_leds(v, k));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        exit_valid = 1'b0;
        exit_value = 32'd0;
        clear      = 1'b0;
        test_reset();
        test_pass();
        test_blink();
        test_clear_held();
        test_clear_rise();
        test_reset_gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
